cic_interpolator: RTL and testbench
===================================

Name: cic_interpolator

Overview:
Transmit-direction counterpart of the receive-chain CIC decimator in the DFE. It takes a low-rate 16-bit sample stream and raises the rate by a run-time factor R (1..16) to the single 18 MHz CLK. Structure: N_STAGES comb sections at input rate, zero-stuff upsampler, N_STAGES integrators at CLK rate, gain-normalising shifter. Input uses a pull (ready/valid) handshake; output is one sample per CLK cycle while enabled.

Parameters:
DATA_WIDTH, 16, input/output sample width (signed two's complement)
N_STAGES, 3, number of comb and number of integrator stages
R_MAX, 16, maximum interpolation factor
ACC_WIDTH, DATA_WIDTH + N_STAGES*clog2(R_MAX) = 28, internal comb/integrator width

Ports:
CLK  in  1  system clock, 18 MHz
RST  in  1  asynchronous active-low reset
filter_enable  in  1  run enable; low = synchronous clear of all state
interp_factor  in  5  interpolation factor R; 0 treated as 1, >16 clamped to 16
data_in  in  DATA_WIDTH  signed input sample
in_valid  in  1  upstream has a sample on data_in
in_ready  out  1  block accepts a sample this cycle
data_out  out  DATA_WIDTH  signed interpolated sample
out_valid  out  1  data_out is a valid output sample
underflow  out  1  sticky: an input slot passed with in_valid low

Behaviour:
- Reset (RST=0, async): all outputs 0; phase counter, combs, integrators, output register 0; R register = 1.
- R latching: interp_factor sampled into R_reg (after clamp) only on cycles where filter_enable=0. Changes while enabled are ignored.
- filter_enable=0: phase counter, comb delays, integrators, pipeline and out_valid cleared synchronously; in_ready=0; underflow cleared.
- Phase counter ph: 0..R_reg-1, increments each enabled cycle, wraps to 0. R_reg=1 → ph is constantly 0.
- in_ready = filter_enable & (ph==0), combinational from registered state.
- Accept: in_ready & in_valid → x = sign-extended data_in. in_ready & !in_valid → x = 0 and underflow set (sticky until disable/reset). Samples presented when in_ready=0 are ignored.
- Combs: on each slot (ph==0), c_k = c_{k-1} - d_k; d_k <= c_{k-1} (differential delay 1). Chain is combinational; final comb result registered into comb_reg on that edge.
- Upsampler: integrator-1 input = comb_reg on the cycle after a slot, 0 on all other cycles.
- Integrators: each registered, i_k <= i_k + i_{k-1}, every enabled cycle. ACC_WIDTH modular wrap is intended; no saturation internally.
- Gain R^(N_STAGES-1) is normalised by an arithmetic right shift S = (N_STAGES-1)*clog2(R_reg); clog2(1)=0. Then saturate to DATA_WIDTH and register into data_out.
- Net gain is exactly 1 for power-of-two R, and <1 otherwise.
- Latency: a sample accepted at edge k affects data_out at edge k+N_STAGES+2 (5 for default).
- out_valid rises on the same edge the first accepted sample's response reaches data_out. It stays 1 every cycle until disable/reset.
- Reset or disable mid-operation: pipeline discarded; the first slot after re-enable is at ph=0 on the first enabled cycle.

Decomposition:
- Shared package dfe_pkg: R_MAX, N_STAGES default, clog2 function, shift-amount function shift_for(R), saturate function.
- One sub-module, cic_int_stage: one registered ACC_WIDTH integrator with sync clear. Instantiated N_STAGES times via generate.
- Combs stay inline (slot-gated, trivial).

Test Plan:
- Step: R=4, in_valid=1, data_in=1000 constant → data_out settles to 1000 and holds. out_valid rises 5 cycles after first accept. in_ready is 1 every 4th cycle.
- Impulse: R=4, one sample 16 then zeros → data_out sequence 1,3,6,10,12,12,10,6,3,1 then 0 (sum 64).
- Non-power-of-two: R=5, constant 1000 → steady data_out = floor(25000/64) = 390. Constant -1000 → -391.
- R=1 and interp_factor=0: in_ready=1 every cycle. data_out equals data_in delayed 5 cycles (ramp 0..99 reproduced exactly).
- Underflow / factor change: R=8 with in_valid low on one slot → that sample taken as 0, underflow=1 sticky. Changing interp_factor while enabled has no effect. Toggling filter_enable low clears underflow and out_valid and loads the new R.
- Async reset mid-stream: RST low between edges → all outputs 0 immediately. After release plus re-enable, step test passes again.

Source files
------------

// File: rtl/dfe_pkg.sv
// dfe_pkg: shared DFE constants and helpers.
// Used by the CIC interpolator and its integrator stage.
package dfe_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int N_STAGES_DEF = 3;
  localparam int R_MAX_DEF    = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int ACC_W_DEF =
    DATA_W_DEF + N_STAGES_DEF * clog2(R_MAX_DEF);

  function automatic int shift_for(
    input int n,
    input int r
  );
    return (n - 1) * clog2(r);
  endfunction

  function automatic logic [4:0] clamp_r(
    input logic [4:0] f,
    input int         rmax
  );
    if (f == 5'd0) return 5'd1;
    if (int'(f) > rmax) return 5'(rmax);
    return f;
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_int_stage.sv
// cic_int_stage: one registered CIC integrator.
// Wraps modulo 2^WIDTH; cleared while disabled.
module cic_int_stage
  import dfe_pkg::*;
#(
  parameter int WIDTH = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (!en) begin
      dout <= '0;
    end else begin
      dout <= dout + din;
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator, runtime factor 1..16.
// Combs at input rate, zero-stuff, integrators at clock rate, shift-normalised.
module cic_interpolator
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int N_STAGES   = N_STAGES_DEF,
  parameter int R_MAX      = R_MAX_DEF,
  parameter int ACC_WIDTH  =
    DATA_WIDTH + N_STAGES * clog2(R_MAX)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         filter_enable,
  input  logic [4:0]                   interp_factor,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         out_valid,
  output logic                         underflow
);

  logic [4:0]                  r_reg;
  logic [4:0]                  ph;
  logic                        slot;
  logic                        slot_d;
  logic [N_STAGES+2:0]         vp;
  logic [7:0]                  shamt;
  logic signed [ACC_WIDTH-1:0] x;
  logic signed [ACC_WIDTH-1:0] comb_reg;
  logic signed [ACC_WIDTH-1:0] shreg;
  logic signed [ACC_WIDTH-1:0] c [N_STAGES+1];
  logic signed [ACC_WIDTH-1:0] d [N_STAGES];
  logic signed [ACC_WIDTH-1:0] integ [N_STAGES+1];

  assign slot      = (ph == 5'd0);
  assign in_ready  = RST & filter_enable & slot;
  assign x         = in_valid ? ACC_WIDTH'(data_in) : '0;
  assign shamt     = 8'(shift_for(N_STAGES, int'(r_reg)));
  assign out_valid = vp[N_STAGES+2];

  // Zero-stuffing: comb result enters the integrators for one cycle only
  assign integ[0] = slot_d ? comb_reg : '0;

  always_comb begin
    c[0] = x;
    for (int k = 0; k < N_STAGES; k++)
      c[k+1] = c[k] - d[k];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ph        <= '0;
      r_reg     <= 5'd1;
      slot_d    <= 1'b0;
      comb_reg  <= '0;
      underflow <= 1'b0;
      vp        <= '0;
      for (int k = 0; k < N_STAGES; k++)
        d[k] <= '0;
    end else if (!filter_enable) begin
      ph        <= '0;
      r_reg     <= clamp_r(interp_factor, R_MAX);
      slot_d    <= 1'b0;
      comb_reg  <= '0;
      underflow <= 1'b0;
      vp        <= '0;
      for (int k = 0; k < N_STAGES; k++)
        d[k] <= '0;
    end else begin
      ph     <= (ph == r_reg - 5'd1) ? '0 : ph + 5'd1;
      slot_d <= slot;
      // Valid token tracks the first accepted sample down the pipe
      vp     <= {vp[N_STAGES+1:0], vp[0] | (slot & in_valid)};
      if (slot) begin
        for (int k = 0; k < N_STAGES; k++)
          d[k] <= c[k];
        comb_reg <= c[N_STAGES];
        if (!in_valid) underflow <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_int
    cic_int_stage #(
      .WIDTH(ACC_WIDTH)
    ) u_int (
      .clk  (CLK),
      .rst_n(RST),
      .en   (filter_enable),
      .din  (integ[k]),
      .dout (integ[k+1])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg    <= '0;
      data_out <= '0;
    end else if (!filter_enable) begin
      shreg    <= '0;
      data_out <= '0;
    end else begin
      shreg    <= integ[N_STAGES] >>> shamt;
      data_out <= DATA_WIDTH'(saturate(64'(shreg), DATA_WIDTH));
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed self-checking bench for cic_interpolator.
// Expected values are hand-derived CIC responses.
module tb_cic_interpolator;

  logic               CLK;
  logic               RST;
  logic               filter_enable;
  logic [4:0]         interp_factor;
  logic signed [15:0] data_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] data_out;
  logic               out_valid;
  logic               underflow;

  int total = 0;
  int bad   = 0;
  int h [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

  cic_interpolator dut (
    .CLK          (CLK),
    .RST          (RST),
    .filter_enable(filter_enable),
    .interp_factor(interp_factor),
    .data_in      (data_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .underflow    (underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // R=4 step of 1000: floor(1000*s/16), s = 1,3,6,10,13,15,16...
  task automatic run_step_test(input string tag);
    int tr [6] = '{62, 187, 375, 625, 812, 937};
    int e;
    filter_enable = 1'b1;
    in_valid      = 1'b1;
    data_in       = 16'sd1000;
    #1;
    chk({tag, "_rdy0"}, in_ready, 1);
    for (int j = 1; j <= 30; j++) begin
      step();
      chk({tag, "_rdy"}, in_ready, (j % 4 == 0));
      chk({tag, "_ovld"}, out_valid, (j >= 6));
      e = (j < 6) ? 0 : ((j < 12) ? tr[j-6] : 1000);
      chk({tag, "_dout"}, data_out, e);
    end
  endtask

  initial begin
    int e;
    RST           = 1'b0;
    filter_enable = 1'b0;
    interp_factor = 5'd4;
    data_in       = '0;
    in_valid      = 1'b0;
    step();
    step();
    chk("rst_dout", data_out, 0);
    chk("rst_ovld", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_udf", underflow, 0);

    // Step response, R=4
    RST = 1'b1;
    step();
    run_step_test("step");

    // Impulse, R=4
    filter_enable = 1'b0;
    step();
    filter_enable = 1'b1;
    in_valid      = 1'b1;
    data_in       = 16'sd16;
    step();
    chk("imp_first", data_out, 0);
    data_in = '0;
    for (int j = 2; j <= 18; j++) begin
      step();
      e = (j >= 6 && j <= 15) ? h[j-6] : 0;
      chk("imp_dout", data_out, e);
    end

    // Non power of two, R=5
    interp_factor = 5'd5;
    filter_enable = 1'b0;
    step();
    filter_enable = 1'b1;
    data_in       = 16'sd1000;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j >= 30) chk("r5_pos", data_out, 390);
    end
    data_in = -16'sd1000;
    for (int j = 1; j <= 40; j++) begin
      step();
      if (j >= 30) chk("r5_neg", data_out, -391);
    end

    // R=1 via factor 0, ramp passthrough
    interp_factor = 5'd0;
    filter_enable = 1'b0;
    step();
    filter_enable = 1'b1;
    data_in       = '0;
    for (int j = 1; j <= 106; j++) begin
      step();
      chk("r1_rdy", in_ready, 1);
      e = 0;
      if (j >= 6 && j - 6 < 100) e = j - 6;
      chk("r1_dout", data_out, e);
      data_in = (j < 100) ? 16'(j) : 16'sd0;
    end

    // Clamp: factor 20 behaves as 16
    interp_factor = 5'd20;
    filter_enable = 1'b0;
    step();
    filter_enable = 1'b1;
    for (int j = 1; j <= 34; j++) begin
      step();
      chk("clamp_rdy", in_ready, (j % 16 == 0));
    end

    // Underflow and ignored factor change, R=8
    interp_factor = 5'd8;
    filter_enable = 1'b0;
    step();
    filter_enable = 1'b1;
    in_valid      = 1'b1;
    data_in       = 16'sd1000;
    for (int j = 1; j <= 16; j++) begin
      step();
      chk("udf_clear", underflow, 0);
    end
    in_valid      = 1'b0;
    interp_factor = 5'd2;
    step();
    chk("udf_set", underflow, 1);
    in_valid = 1'b1;
    for (int j = 18; j <= 60; j++) begin
      step();
      chk("udf_sticky", underflow, 1);
      chk("r8_rdy", in_ready, (j % 8 == 0));
      if (j >= 55) chk("r8_dout", data_out, 1000);
    end
    filter_enable = 1'b0;
    step();
    chk("dis_udf", underflow, 0);
    chk("dis_ovld", out_valid, 0);
    chk("dis_rdy", in_ready, 0);
    chk("dis_dout", data_out, 0);
    filter_enable = 1'b1;
    data_in       = 16'sd500;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("r2_rdy", in_ready, (j % 2 == 0));
    end
    in_valid = 1'b0;
    step();
    chk("r2_udf", underflow, 1);
    in_valid = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_rdy", in_ready, 1);
    chk("pre_rst_ovld", out_valid, 1);

    // Async reset between edges
    #3;
    RST = 1'b0;
    #1;
    chk("arst_dout", data_out, 0);
    chk("arst_ovld", out_valid, 0);
    chk("arst_rdy", in_ready, 0);
    chk("arst_udf", underflow, 0);
    filter_enable = 1'b0;
    interp_factor = 5'd4;
    #1;
    RST = 1'b1;
    step();
    run_step_test("rstep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
